// File: rtl/multicycle_ctrl.sv
// Control FSM for the shared multi-cycle MIPS datapath: decodes the IR opcode,
// sequences the per-cycle datapath enables and guards every memory wait with a timeout.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_beq,
  output logic       pc_write_bne,
  output logic       pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluop,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state
);

  // state   | meaning
  // FETCH   | read instruction at PC, PC+4 into PC on mem_ready
  // DECODE  | branch target into ALUOut, dispatch on opcode
  // MEMADR  | effective address for lw/sw
  // MEMRD   | data read at ALUOut
  // MEMWB   | MDR into rt
  // MEMWR   | data write at ALUOut
  // EXEC    | R-type ALU operation
  // ALUWB   | ALUOut into rd
  // BRANCH  | compare, conditional PC load
  // ADDIEX  | A + sign-extended immediate
  // ADDIWB  | ALUOut into rt
  // ERROR   | memory timeout, outputs idle until reset
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_ERROR  = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    op_q, op_d;
  logic          mem_err_q, mem_err_d;
  logic          timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      op_q      <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Last allowed wait cycle: mem_ready here still completes normally.
  assign timeout = (cnt_q == CNT_LAST) && !mem_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    mem_err_d    = mem_err_q;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    iord         = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_write_beq = 1'b0;
    pc_write_bne = 1'b0;
    pc_source    = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    aluop        = 2'b00;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    illegal_op   = 1'b0;
    state        = state_q;
    mem_err      = mem_err_q;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout) begin
          state_d   = S_ERROR;
          mem_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        op_d      = opcode;
        case (opcode)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_ADDI:        state_d = S_ADDIEX;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_RTYPE:       state_d = S_EXEC;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (timeout) begin
          state_d   = S_ERROR;
          mem_err_d = 1'b1;
        end
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d   = S_ERROR;
          mem_err_d = 1'b1;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        aluop     = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a    = 1'b1;
        aluop        = 2'b01;
        pc_source    = 1'b1;
        pc_write_beq = (op_q == OP_BEQ);
        pc_write_bne = (op_q == OP_BNE);
        state_d      = S_FETCH;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_FETCH;
    endcase

    // Any state change restarts the wait count for the next memory state.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR) && !mem_ready) begin
      cnt_d = cnt_q + CW'(1);
    end

    if (reset) begin
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      iord         = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_write_beq = 1'b0;
      pc_write_bne = 1'b0;
      pc_source    = 1'b0;
      alu_src_a    = 1'b0;
      alu_src_b    = 2'b00;
      aluop        = 2'b00;
      reg_dst      = 1'b0;
      mem_to_reg   = 1'b0;
      reg_write    = 1'b0;
      illegal_op   = 1'b0;
      state        = 4'd0;
      mem_err      = 1'b0;
    end
  end

endmodule
